wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter and scoreboard that shares the register file's single write port between the in-order pipeline write-back stage and the multi-cycle unit (mul/div).
- Drives the register file's write enable, write address and write data, and returns a ready to the multi-cycle unit.
- Keeps a 32-entry busy scoreboard so decode can stall on operands whose multi-cycle result is still outstanding.
- Bounds starvation of the multi-cycle unit by briefly stalling the pipeline.

## Interface
Parameters:
- STARVE_MAX, 4: number of consecutive cycles the multi-cycle unit may be refused before the pipeline is stalled. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- p_valid  in  1  pipeline write-back request; it has no ready.
- p_reg  in  5  pipeline destination register.
- p_data  in  32  pipeline write data.
- m_valid  in  1  multi-cycle unit result valid.
- m_ready  out  1  multi-cycle result accepted this cycle.
- m_reg  in  5  multi-cycle destination register.
- m_data  in  32  multi-cycle write data.
- iss_valid  in  1  decode issues a multi-cycle op this cycle.
- iss_reg  in  5  destination register of the issued op.
- read1, read2  in  5 each  decode source register numbers.
- hz1, hz2  out  1 each  busy[read1], busy[read2].
- hz_dst  out  1  busy[iss_reg].
- pipe_stall  out  1  registered; freezes the pipeline write-back stage.
- rf_regwrite  out  1  register file write enable.
- rf_wrreg  out  5  register file write address.
- rf_wrdata  out  32  register file write data.
- err  out  1  sticky protocol violation flag.
- fwd1_hit, fwd2_hit  out  1 each  bypass match; present only with bypass enabled.
- fwd1_data, fwd2_data  out  32 each  bypass data; present only with bypass enabled.

## Operation
- Grant, evaluated combinationally each cycle:
  - If p_valid && !pipe_stall: pipeline wins. rf_* carry the p_* values and m_ready=0.
  - Otherwise m_ready=1. When m_valid is also 1, rf_* carry the m_* values.
- pipe_stall=1 means the pipeline is holding write-back, so p_valid is ignored that cycle.
- Register 0: a grant to reg 0 drives rf_regwrite=0. The handshake still completes (m_ready stays as computed).
- When nothing is granted, rf_regwrite=0 and rf_wrreg/rf_wrdata=0.
- Starvation counter (4 bits):
  - Increments on m_valid && !m_ready.
  - Clears on any m handshake, or when m_valid=0.
  - When it reaches STARVE_MAX, pipe_stall is set on the next edge and the counter clears.
  - pipe_stall is high for exactly one cycle. During that cycle the multi-cycle unit is guaranteed the port.
- Scoreboard, 32 bits:
  - Bit set on iss_valid && iss_reg!=0.
  - Bit cleared on m_valid && m_ready for m_reg.
  - Set and clear of the same register in the same cycle: set wins.
  - busy[0] is always 0.
- hz1, hz2 and hz_dst are combinational reads of the current scoreboard.
- Issuing to an already-busy register is illegal. err is set on the next edge and stays set until reset. The scoreboard bit stays 1.
- A multi-cycle handshake to a non-busy register also sets err.

## Timing
- Grant to register-file write has zero added latency: the register file writes on the same rising edge as the handshake.
- Scoreboard changes are visible on hz* the cycle after the issue or the handshake edge.
- Worst-case wait for the multi-cycle unit: STARVE_MAX+1 cycles from m_valid to m_ready.
- Reset values: busy=0, counter=0, pipe_stall=0, err=0.
  - Combinational outputs follow their inputs from that state, so m_ready=1 unless p_valid, and rf_regwrite=0 unless a request is present.
- Reset asserted mid-operation clears all state immediately. A multi-cycle result pending at that moment is lost; the unit is reset too.

## Configuration
- WBARB_BYPASS_EN defined:
  - fwdN_hit = rf_regwrite && rf_wrreg==readN.
  - fwdN_data = rf_wrdata when fwdN_hit, otherwise 0.
  - Decode muxes fwdN_data over the register file's read data, so a same-cycle write is seen.
- WBARB_BYPASS_EN undefined:
  - The fwd ports are absent.
  - Decode must stall one cycle on a same-cycle write to a source register.

## Structure
- Shared package wb_pkg holds the constants REG_W=5, DATA_W=32, NREGS=32 and ZERO_REG=0.
- One sub-module, wb_scoreboard, holds the busy vector, its set/clear logic, the three lookups and err.
- Grant logic, starvation counter and bypass live in the top module.

## Test plan
- Idle pipeline, m_valid with m_reg=5, m_data=0xDEADBEEF → m_ready=1, rf_regwrite=1, rf_wrreg=5, rf_wrdata=0xDEADBEEF in the same cycle.
- p_valid held high with STARVE_MAX=4, m_valid high → m_ready=0 for 4 cycles, pipe_stall=1 in cycle 5, m granted in cycle 5, pipe_stall=0 in cycle 6.
- iss_valid with iss_reg=7 → hz1=1 for read1=7 from the next cycle; after the m handshake on reg 7, hz1=0 the following cycle.
- Same cycle: iss_reg=9 while an m handshake completes for reg 9 (already busy) → busy[9] stays 1, err stays 0.
- iss_reg=9 while busy[9]=1 and no clear → err=1 and stays 1 until rst_n low. Handshake with m_reg=0 → rf_regwrite=0, m_ready=1, err=1.
- With WBARB_BYPASS_EN: p_valid, p_reg=3, p_data=0x1234, read2=3 → fwd2_hit=1, fwd2_data=0x1234. Assert rst_n low mid-stall → pipe_stall=0, all hz=0 immediately.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and the register-file write-port bundle used by
// the write-back arbiter and its scoreboard.
package wb_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  // One register-file write: enable, address, data.
  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wr_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: busy bit per architectural register for outstanding
// multi-cycle results, plus the sticky protocol error flag.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   iss_valid, iss_reg  decode issues a multi-cycle op to iss_reg (sets busy)
//   clr, clr_reg        multi-cycle handshake completes for clr_reg (clears busy)
//   read1, read2        decode source registers
//   hz1, hz2, hz_dst    busy[read1], busy[read2], busy[iss_reg]
//   err                 sticky: issue to busy reg, or handshake to idle reg
module wb_scoreboard import wb_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_valid,
  input  logic [REG_W-1:0] iss_reg,
  input  logic             clr,
  input  logic [REG_W-1:0] clr_reg,
  input  logic [REG_W-1:0] read1,
  input  logic [REG_W-1:0] read2,
  output logic             hz1,
  output logic             hz2,
  output logic             hz_dst,
  output logic             err
);
  logic [NREGS-1:0] busy, busy_next;
  logic             set, err_set;

  assign set = iss_valid && (iss_reg != ZERO_REG);

  always_comb begin
    busy_next = busy;
    if (clr) busy_next[clr_reg] = 1'b0;
    if (set) busy_next[iss_reg] = 1'b1;   // set wins over same-cycle clear
    busy_next[0] = 1'b0;
  end

  // A re-issue to a register whose result retires this same cycle is legal.
  always_comb begin
    err_set = 1'b0;
    if (set && busy[iss_reg] && !(clr && clr_reg == iss_reg)) err_set = 1'b1;
    if (clr && !busy[clr_reg])                                err_set = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busy_next;
      if (err_set) err <= 1'b1;
    end
  end

  assign hz1    = busy[read1];
  assign hz2    = busy[read2];
  assign hz_dst = busy[iss_reg];
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register file's single write port between the
// pipeline write-back stage (no ready, normally wins) and the multi-cycle
// unit, with a starvation bound that stalls the pipeline for one cycle.
// Build option: define WBARB_BYPASS_EN to add same-cycle write forwarding
// ports fwd1_hit/fwd1_data/fwd2_hit/fwd2_data.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   p_valid/p_reg/p_data         pipeline write-back request
//   m_valid/m_ready/m_reg/m_data multi-cycle result handshake
//   iss_valid/iss_reg            multi-cycle issue (marks dest busy)
//   read1/read2, hz1/hz2/hz_dst  scoreboard lookups
//   pipe_stall                   registered one-cycle write-back freeze
//   rf_regwrite/rf_wrreg/rf_wrdata register file write port
//   err                          sticky protocol violation
module wb_arbiter import wb_pkg::*; #(
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_valid,
  input  logic [REG_W-1:0]  p_reg,
  input  logic [DATA_W-1:0] p_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [REG_W-1:0]  m_reg,
  input  logic [DATA_W-1:0] m_data,
  input  logic              iss_valid,
  input  logic [REG_W-1:0]  iss_reg,
  input  logic [REG_W-1:0]  read1,
  input  logic [REG_W-1:0]  read2,
  output logic              hz1,
  output logic              hz2,
  output logic              hz_dst,
  output logic              pipe_stall,
  output logic              rf_regwrite,
  output logic [REG_W-1:0]  rf_wrreg,
  output logic [DATA_W-1:0] rf_wrdata,
`ifdef WBARB_BYPASS_EN
  output logic              fwd1_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd2_data,
`endif
  output logic              err
);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  wr_t        wr;
  logic       m_hs;
  logic [3:0] cnt, cnt_inc;

  // Grant: pipeline first unless it is frozen by pipe_stall.
  always_comb begin
    wr      = '0;
    m_ready = 1'b1;
    if (p_valid && !pipe_stall) begin
      m_ready = 1'b0;
      wr.we   = (p_reg != ZERO_REG);
      wr.addr = p_reg;
      wr.data = p_data;
    end else if (m_valid) begin
      wr.we   = (m_reg != ZERO_REG);
      wr.addr = m_reg;
      wr.data = m_data;
    end
  end

  assign m_hs        = m_valid && m_ready;
  assign rf_regwrite = wr.we;
  assign rf_wrreg    = wr.addr;
  assign rf_wrdata   = wr.data;

  // Starvation: the edge that would bring the count to the limit raises
  // pipe_stall instead, so the unit is served on the (STARVE_MAX+1)th cycle.
  // A refusal implies !pipe_stall, so stalls never repeat back to back.
  assign cnt_inc = cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      pipe_stall <= 1'b0;
    end else begin
      pipe_stall <= 1'b0;
      if (m_valid && !m_ready) begin
        if (cnt_inc == STARVE_LIM) begin
          cnt        <= '0;
          pipe_stall <= 1'b1;
        end else begin
          cnt <= cnt_inc;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  wb_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_valid(iss_valid),
    .iss_reg  (iss_reg),
    .clr      (m_hs),
    .clr_reg  (m_reg),
    .read1    (read1),
    .read2    (read2),
    .hz1      (hz1),
    .hz2      (hz2),
    .hz_dst   (hz_dst),
    .err      (err)
  );

`ifdef WBARB_BYPASS_EN
  assign fwd1_hit  = wr.we && (wr.addr == read1);
  assign fwd2_hit  = wr.we && (wr.addr == read2);
  assign fwd1_data = fwd1_hit ? wr.data : '0;
  assign fwd2_data = fwd2_hit ? wr.data : '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_valid, m_valid, iss_valid;
  logic [4:0]  p_reg, m_reg, iss_reg, read1, read2;
  logic [31:0] p_data, m_data;
  logic        m_ready, hz1, hz2, hz_dst, pipe_stall, rf_regwrite, err;
  logic [4:0]  rf_wrreg;
  logic [31:0] rf_wrdata;
`ifdef WBARB_BYPASS_EN
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_valid(p_valid), .p_reg(p_reg), .p_data(p_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_reg(m_reg), .m_data(m_data),
    .iss_valid(iss_valid), .iss_reg(iss_reg),
    .read1(read1), .read2(read2),
    .hz1(hz1), .hz2(hz2), .hz_dst(hz_dst),
    .pipe_stall(pipe_stall),
    .rf_regwrite(rf_regwrite), .rf_wrreg(rf_wrreg), .rf_wrdata(rf_wrdata),
`ifdef WBARB_BYPASS_EN
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
`endif
    .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit past the next rising edge; inputs are driven here
  // and outputs are sampled #1 later, well clear of both edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; p_valid = 0; m_valid = 0; iss_valid = 0;
    p_reg = 0; m_reg = 0; iss_reg = 0; read1 = 0; read2 = 0;
    p_data = 0; m_data = 0;
    #12;
    chk("rst_stall", pipe_stall, 0);
    chk("rst_err", err, 0);
    chk("rst_mready", m_ready, 1);
    chk("rst_we", rf_regwrite, 0);
    chk("rst_hz", {hz1, hz2, hz_dst}, 0);
    rst_n = 1'b1;
    tick();

    // issue reg 5, then m result for reg 5 with idle pipeline
    iss_valid = 1; iss_reg = 5;
    tick();
    iss_valid = 0; read1 = 5;
    m_valid = 1; m_reg = 5; m_data = 32'hDEADBEEF;
    #1;
    chk("m_ready_idle", m_ready, 1);
    chk("m_we", rf_regwrite, 1);
    chk("m_wrreg", rf_wrreg, 5);
    chk("m_wrdata", rf_wrdata, 32'hDEADBEEF);
    chk("hz5_busy", hz1, 1);
    tick();
    m_valid = 0;
    #1;
    chk("hz5_clear", hz1, 0);
    chk("nothing_we", rf_regwrite, 0);
    chk("nothing_data", rf_wrdata, 0);

    // scoreboard on reg 7
    iss_valid = 1; iss_reg = 7; read1 = 7;
    #1;
    chk("hz7_before", hz1, 0);
    tick();
    iss_valid = 0;
    #1;
    chk("hz7_set", hz1, 1);
    m_valid = 1; m_reg = 7; m_data = 32'h77;
    tick();
    m_valid = 0;
    #1;
    chk("hz7_clr", hz1, 0);
    chk("err_clean", err, 0);

    // starvation: reg 10 busy, pipeline hogs the port
    iss_valid = 1; iss_reg = 10;
    tick();
    iss_valid = 0;
    p_valid = 1; p_reg = 2; p_data = 32'h11;
    m_valid = 1; m_reg = 10; m_data = 32'hA0A0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("starve_mready_c%0d", c), m_ready, 0);
      chk($sformatf("starve_stall_c%0d", c), pipe_stall, 0);
      chk($sformatf("starve_wrreg_c%0d", c), rf_wrreg, 2);
      tick();
    end
    #1;
    chk("stall_c5", pipe_stall, 1);
    chk("mready_c5", m_ready, 1);
    chk("wrreg_c5", rf_wrreg, 10);
    chk("wrdata_c5", rf_wrdata, 32'hA0A0);
    tick();
    m_valid = 0;
    #1;
    chk("stall_c6", pipe_stall, 0);
    chk("mready_c6", m_ready, 0);
    chk("wrreg_c6", rf_wrreg, 2);
    p_valid = 0;
    tick();

    // same-cycle set and clear of reg 9
    iss_valid = 1; iss_reg = 9;
    tick();
    m_valid = 1; m_reg = 9; m_data = 32'h99;
    tick();
    iss_valid = 0; m_valid = 0; read1 = 9;
    #1;
    chk("setwins_busy", hz1, 1);
    chk("setwins_err", err, 0);

    // illegal re-issue of busy reg 9
    iss_valid = 1; iss_reg = 9;
    tick();
    iss_valid = 0;
    #1;
    chk("reissue_err", err, 1);
    chk("reissue_busy", hz1, 1);
    tick(); tick();
    chk("err_sticky", err, 1);

    // handshake to reg 0
    m_valid = 1; m_reg = 0; m_data = 32'h5555;
    #1;
    chk("r0_we", rf_regwrite, 0);
    chk("r0_mready", m_ready, 1);
    tick();
    m_valid = 0;
    #1;
    chk("r0_err", err, 1);

`ifdef WBARB_BYPASS_EN
    p_valid = 1; p_reg = 3; p_data = 32'h1234; read1 = 4; read2 = 3;
    #1;
    chk("fwd2_hit", fwd2_hit, 1);
    chk("fwd2_data", fwd2_data, 32'h1234);
    chk("fwd1_hit", fwd1_hit, 0);
    chk("fwd1_data", fwd1_data, 0);
    p_valid = 0;
    tick();
`endif

    // reset in the middle of a stall cycle; reg 9 still busy
    iss_valid = 1; iss_reg = 12;
    tick();
    iss_valid = 0;
    p_valid = 1; p_reg = 2; p_data = 32'h22;
    m_valid = 1; m_reg = 12; m_data = 32'hC;
    tick(); tick(); tick(); tick();
    read1 = 9; read2 = 12; iss_reg = 9;
    #1;
    chk("mid_stall", pipe_stall, 1);
    chk("mid_hz", {hz1, hz2, hz_dst}, 3'b111);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_stall", pipe_stall, 0);
    chk("rst_mid_hz", {hz1, hz2, hz_dst}, 0);
    chk("rst_mid_err", err, 0);
    p_valid = 0; m_valid = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
